// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, keyboard command bytes and default timing.
package ps2_pkg;

  localparam int unsigned TIMER_W  = 20;
  localparam int unsigned BITCNT_W = 4;

  localparam int unsigned DEF_INHIBIT_CYCLES = 6500;
  localparam int unsigned DEF_START_TIMEOUT  = 975000;
  localparam int unsigned DEF_XFER_TIMEOUT   = 130000;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE,
    OK,
    FAIL
  } ps2_state_t;

  // Latched command byte together with its odd-parity bit.
  typedef struct packed {
    logic       parity;
    logic [7:0] data;
  } ps2_frame_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake and status between a requester and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, busy, done, error
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, busy, done, error
  );
endinterface

// File: rtl/ps2_line_sync.sv
// Three-flop synchronisers for the raw PS/2 pins plus clock falling-edge detect.
module ps2_line_sync (
  input  logic clock_65mhz,
  input  logic reset_n,
  input  logic ps2_clock_in,
  input  logic ps2_data_in,
  output logic clock_level,
  output logic data_level,
  output logic clock_fall_c
);

  logic [2:0] clock_sync;
  logic [2:0] data_sync;

  // Idle PS/2 lines are high, so reset the chains to 1 to avoid a spurious fall.
  always_ff @(posedge clock_65mhz or negedge reset_n) begin
    if (!reset_n) begin
      clock_sync <= 3'b111;
      data_sync  <= 3'b111;
    end else begin
      clock_sync <= {clock_sync[1:0], ps2_clock_in};
      data_sync  <= {data_sync[1:0], ps2_data_in};
    end
  end

  assign clock_level  = clock_sync[1];
  assign data_level   = data_sync[1];
  assign clock_fall_c = clock_sync[2] & ~clock_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-collector clock/data enables.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int unsigned START_TIMEOUT  = DEF_START_TIMEOUT,
  parameter int unsigned XFER_TIMEOUT   = DEF_XFER_TIMEOUT
) (
  input  logic          clock_65mhz,
  input  logic          reset_n,
  ps2_host_tx_if.slave  tx,
  input  logic          ps2_clock_in,
  input  logic          ps2_data_in,
  output logic          ps2_clock_oe,
  output logic          ps2_data_oe
);

  ps2_state_t            state_q, state_d;
  ps2_frame_t            frame_q, frame_d;
  logic [BITCNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [TIMER_W-1:0]    timer_q, timer_d, timer_inc;
  logic                  clock_oe_q, clock_oe_d;
  logic                  data_oe_q, data_oe_d;
  logic                  tx_ready_q, busy_q, done_q, error_q;

  logic                  clock_level, data_level, clock_fall;

  ps2_line_sync u_sync (
    .clock_65mhz  (clock_65mhz),
    .reset_n      (reset_n),
    .ps2_clock_in (ps2_clock_in),
    .ps2_data_in  (ps2_data_in),
    .clock_level  (clock_level),
    .data_level   (data_level),
    .clock_fall_c (clock_fall)
  );

  // Saturating increment so a stuck line can never wrap the timer back under a limit.
  assign timer_inc = (&timer_q) ? timer_q : timer_q + TIMER_W'(1);

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    bitcnt_d   = bitcnt_q;
    timer_d    = timer_inc;
    data_oe_d  = data_oe_q;
    clock_oe_d = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d   = '0;
        bitcnt_d  = '0;
        data_oe_d = 1'b0;
        if (tx.tx_valid && tx_ready_q) begin
          frame_d = '{parity: odd_parity(tx.tx_data), data: tx.tx_data};
          state_d = INHIBIT;
        end
      end

      INHIBIT: begin
        if (timer_q >= TIMER_W'(INHIBIT_CYCLES - 1)) begin
          state_d   = REQ;
          timer_d   = '0;
          data_oe_d = 1'b1;
        end
      end

      REQ: begin
        if (clock_fall) begin
          data_oe_d = ~frame_q.data[0];
          bitcnt_d  = BITCNT_W'(1);
          timer_d   = '0;
          state_d   = SEND;
        end else if (timer_q >= TIMER_W'(START_TIMEOUT)) begin
          state_d = FAIL;
        end
      end

      SEND: begin
        if (timer_q >= TIMER_W'(XFER_TIMEOUT)) begin
          state_d = FAIL;
        end else if (clock_fall) begin
          if (bitcnt_q < BITCNT_W'(8)) begin
            data_oe_d = ~frame_q.data[bitcnt_q[2:0]];
            bitcnt_d  = bitcnt_q + BITCNT_W'(1);
          end else if (bitcnt_q == BITCNT_W'(8)) begin
            data_oe_d = ~frame_q.parity;
            bitcnt_d  = BITCNT_W'(9);
          end else begin
            data_oe_d = 1'b0;
            state_d   = ACK;
          end
        end
      end

      ACK: begin
        if (timer_q >= TIMER_W'(XFER_TIMEOUT)) begin
          state_d = FAIL;
        end else if (clock_fall) begin
          state_d = data_level ? FAIL : WAIT_IDLE;
        end
      end

      WAIT_IDLE: begin
        if (timer_q >= TIMER_W'(XFER_TIMEOUT)) begin
          state_d = FAIL;
        end else if (clock_level && data_level) begin
          state_d = OK;
        end
      end

      OK:      state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Line enables follow the next state so they line up with it cycle-for-cycle.
    clock_oe_d = (state_d == INHIBIT);
    if (state_d == FAIL || state_d == IDLE) begin
      data_oe_d = 1'b0;
    end
  end

  always_ff @(posedge clock_65mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      bitcnt_q   <= '0;
      timer_q    <= '0;
      clock_oe_q <= 1'b0;
      data_oe_q  <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      bitcnt_q   <= bitcnt_d;
      timer_q    <= timer_d;
      clock_oe_q <= clock_oe_d;
      data_oe_q  <= data_oe_d;
      tx_ready_q <= (state_d == IDLE);
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == OK);
      error_q    <= (state_d == FAIL);
    end
  end

  assign ps2_clock_oe = clock_oe_q;
  assign ps2_data_oe  = data_oe_q;
  assign tx.tx_ready  = tx_ready_q;
  assign tx.busy      = busy_q;
  assign tx.done      = done_q;
  assign tx.error     = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a model keyboard and a line-bit scoreboard.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned INH = 6500;
  localparam int unsigned ST  = 10000;
  localparam int unsigned XT  = 3000;
  localparam int unsigned HP  = 20;

  logic clock_65mhz = 1'b0;
  logic reset_n     = 1'b0;
  logic dev_clk     = 1'b1;
  logic dev_data    = 1'b1;
  logic ps2_clock_oe, ps2_data_oe;
  logic ps2_clock_in, ps2_data_in;

  always #5 clock_65mhz = ~clock_65mhz;

  // Open-collector wired-AND of host and device drivers.
  assign ps2_clock_in = dev_clk & ~ps2_clock_oe;
  assign ps2_data_in  = dev_data & ~ps2_data_oe;

  ps2_host_tx_if tx ();

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .START_TIMEOUT  (ST),
    .XFER_TIMEOUT   (XT)
  ) dut (
    .clock_65mhz  (clock_65mhz),
    .reset_n      (reset_n),
    .tx           (tx),
    .ps2_clock_in (ps2_clock_in),
    .ps2_data_in  (ps2_data_in),
    .ps2_clock_oe (ps2_clock_oe),
    .ps2_data_oe  (ps2_data_oe)
  );

  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0, err_cnt = 0, both_cnt = 0;
  bit   post_pulse = 1'b0;
  logic rdy_after = 1'b0, coe_after = 1'b1, doe_after = 1'b1;
  logic exp_q[$];

  // Pulse monitor: counts done/error and captures the state one cycle after a pulse.
  always @(negedge clock_65mhz) begin
    if (post_pulse) begin
      rdy_after = tx.tx_ready;
      coe_after = ps2_clock_oe;
      doe_after = ps2_data_oe;
    end
    post_pulse = tx.done | tx.error;
    if (tx.done)              done_cnt++;
    if (tx.error)             err_cnt++;
    if (tx.done && tx.error)  both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock_65mhz);
  endtask

  task automatic sample_bit(input string tag);
    logic e;
    chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk(tag, 32'(ps2_data_in), 32'(e));
    end
  endtask

  // Offer a byte, optionally queue its expected line frame, and time the inhibit phase.
  task automatic send_cmd(input logic [7:0] b, input bit push);
    int n;
    tick(1);
    tx.tx_valid = 1'b1;
    tx.tx_data  = b;
    if (push) begin
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
      exp_q.push_back(($countones(b) % 2) == 0);
      exp_q.push_back(1'b1);
    end
    tick(1);
    tx.tx_valid = 1'b0;
    chk("busy_after_accept", 32'(tx.busy), 1);
    n = 0;
    while (ps2_clock_oe === 1'b1 && n < int'(INH) + 100) begin
      n++;
      tick(1);
    end
    chk("inhibit_len", 32'(n), 32'(INH));
    chk("req_data_oe", 32'(ps2_data_oe), 1);
    chk("req_clock_oe", 32'(ps2_clock_oe), 0);
  endtask

  // Model keyboard: 11 clock pulses, samples host data on rising edges, optional ACK.
  task automatic dev_xfer(input bit ack, input int reject_at, input int abort_at);
    tick(30);
    sample_bit("start_bit");
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && ack) dev_data = 1'b0;
      dev_clk = 1'b0;
      tick(HP);
      if (k == abort_at) begin
        chk("pre_reset_busy", 32'(tx.busy), 1);
        chk("pre_reset_data_oe", 32'(ps2_data_oe), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_clock_oe", 32'(ps2_clock_oe), 0);
        chk("async_reset_data_oe", 32'(ps2_data_oe), 0);
        chk("async_reset_busy", 32'(tx.busy), 0);
        dev_clk = 1'b1;
        tick(3);
        reset_n = 1'b1;
        exp_q.delete();
        return;
      end
      if (k == reject_at) begin
        chk("ready_low_in_send", 32'(tx.tx_ready), 0);
        tx.tx_valid = 1'b1;
        tx.tx_data  = 8'h00;
        tick(1);
        tx.tx_valid = 1'b0;
      end
      dev_clk = 1'b1;
      if (k <= 10) sample_bit($sformatf("frame_bit%0d", k));
      tick(HP);
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_outcome(input int bd, input int be, input bit exp_done, input string tag);
    int w;
    w = 0;
    while (done_cnt + err_cnt == bd + be && w < 500) begin
      tick(1);
      w++;
    end
    tick(3);
    chk({tag, "_done_pulses"}, 32'(done_cnt - bd), 32'(exp_done));
    chk({tag, "_error_pulses"}, 32'(err_cnt - be), 32'(!exp_done));
    chk({tag, "_ready_next"}, 32'(rdy_after), 1);
    chk({tag, "_clock_oe_rel"}, 32'(coe_after), 0);
    chk({tag, "_data_oe_rel"}, 32'(doe_after), 0);
    chk({tag, "_busy_end"}, 32'(tx.busy), 0);
  endtask

  initial begin
    int bd, be, el;
    tx.tx_valid = 1'b0;
    tx.tx_data  = 8'h00;

    tick(3);
    chk("rst_tx_ready", 32'(tx.tx_ready), 1);
    chk("rst_busy", 32'(tx.busy), 0);
    chk("rst_clock_oe", 32'(ps2_clock_oe), 0);
    chk("rst_data_oe", 32'(ps2_data_oe), 0);
    reset_n = 1'b1;
    tick(5);
    chk("idle_done", 32'(tx.done), 0);
    chk("idle_error", 32'(tx.error), 0);
    chk("idle_tx_ready", 32'(tx.tx_ready), 1);

    // Set-LEDs command with ACK.
    bd = done_cnt; be = err_cnt;
    send_cmd(CMD_SET_LEDS, 1'b1);
    dev_xfer(1'b1, 0, 0);
    wait_outcome(bd, be, 1'b1, "set_leds");

    // Enable: five ones gives a zero parity bit.
    bd = done_cnt; be = err_cnt;
    send_cmd(CMD_ENABLE, 1'b1);
    dev_xfer(1'b1, 0, 0);
    wait_outcome(bd, be, 1'b1, "enable");

    // Device never drives ACK low.
    bd = done_cnt; be = err_cnt;
    send_cmd(CMD_ENABLE, 1'b1);
    dev_xfer(1'b0, 0, 0);
    wait_outcome(bd, be, 1'b0, "no_ack");

    // Device never clocks after request-to-send.
    bd = done_cnt; be = err_cnt;
    send_cmd(CMD_RESET, 1'b0);
    el = 0;
    while (tx.error !== 1'b1 && el < int'(ST) + 50) begin
      tick(1);
      el++;
    end
    chk("start_timeout_window", 32'(el >= int'(ST) && el <= int'(ST) + 2), 1);
    wait_outcome(bd, be, 1'b0, "start_timeout");

    // Reset in the middle of a transfer, then a clean transfer afterwards.
    bd = done_cnt; be = err_cnt;
    send_cmd(CMD_SET_LEDS, 1'b1);
    dev_xfer(1'b1, 0, 5);
    tick(50);
    chk("abort_no_done", 32'(done_cnt - bd), 0);
    chk("abort_no_error", 32'(err_cnt - be), 0);
    chk("abort_ready", 32'(tx.tx_ready), 1);
    bd = done_cnt; be = err_cnt;
    send_cmd(CMD_RESET, 1'b1);
    dev_xfer(1'b1, 0, 0);
    wait_outcome(bd, be, 1'b1, "after_abort");

    // A byte offered while busy is dropped, not queued.
    bd = done_cnt; be = err_cnt;
    send_cmd(CMD_SET_LEDS, 1'b1);
    dev_xfer(1'b1, 3, 0);
    wait_outcome(bd, be, 1'b1, "busy_reject");
    tick(50);
    chk("reject_not_queued_busy", 32'(tx.busy), 0);
    chk("reject_not_queued_clk", 32'(ps2_clock_oe), 0);

    chk("sb_drained", 32'(exp_q.size()), 0);
    chk("never_both_pulses", 32'(both_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends single command bytes to the keyboard, such as 0xED set-LEDs, 0xFF reset and 0xF4 enable. It drives the open-collector PS/2 clock and data lines and reports whether the device acknowledged. It shares the physical lines with the existing keyboard receive path, and its busy output lets the top level gate that receiver while a command is being sent.

Parameters:
INHIBIT_CYCLES, 6500, number of clock cycles ps2 clock is held low before request-to-send (about 100 us at 65 MHz).
START_TIMEOUT, 975000, maximum cycles from request-to-send to the first device falling edge (about 15 ms).
XFER_TIMEOUT, 130000, maximum cycles from the first falling edge to both lines idle after ACK (about 2 ms).

Ports:
clock_65mhz  in  1  system clock; the only clock in the block.
reset_n  in  1  asynchronous, active-low reset.
tx_valid  in  1  command byte is offered.
tx_data  in  8  command byte.
tx_ready  out  1  high only in IDLE; a byte is accepted when tx_valid and tx_ready are both high.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when a transfer ends with a valid ACK.
error  out  1  one-cycle pulse when a transfer ends on timeout or missing ACK.
ps2_clock_in  in  1  raw PS/2 clock pin, asynchronous.
ps2_data_in  in  1  raw PS/2 data pin, asynchronous.
ps2_clock_oe  out  1  1 = pull the clock line low; 0 = release it.
ps2_data_oe  out  1  1 = pull the data line low; 0 = release it.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; ps2_clock_oe=0 and ps2_data_oe=0, so both lines are released immediately, even mid-transfer.
  - tx_ready=1 after reset, busy=0, done=0, error=0; bit counter and timer cleared.
- Line synchronisation:
  - 3-flop synchroniser on each PS/2 input.
  - fall = sync[2] & ~sync[1].
  - Events are seen 2-3 cycles after the pin changes.
- Accept: on tx_valid & tx_ready, latch tx_data and parity = ~^tx_data (odd parity), then go to INHIBIT.
  - tx_valid while busy is ignored; the byte is not queued.
- States:
  - INHIBIT: clock_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then REQ.
  - REQ: data_oe=1 (start bit 0), clock_oe=0, timer cleared.
    - First fall: present bit0 (data_oe = ~bit0), bitcnt=1, timer cleared, go to SEND.
    - Timer reaching START_TIMEOUT: go to FAIL.
  - SEND: on each fall, present the next bit.
    - Falls 2-8 present bits 1-7.
    - Fall 9 presents parity.
    - Fall 10 sets data_oe=0 (stop bit 1, line released) and goes to ACK.
  - ACK: on the next fall, sample sync data.
    - Data 0: go to WAIT_IDLE.
    - Data 1: go to FAIL.
  - WAIT_IDLE: when synced clock and data are both 1, go to OK.
  - OK: pulse done for one cycle, then IDLE.
  - FAIL: release both lines, pulse error for one cycle, then IDLE.
- Timeouts:
  - The XFER_TIMEOUT timer runs through SEND, ACK and WAIT_IDLE.
  - Expiry in any of these states goes to FAIL.
  - Timer is 20 bits and saturates; it never wraps.
- Ignored edges: falls during INHIBIT are ignored, since the host owns the clock.
- Line driving: data_oe changes only on the cycle a fall is detected, so the bit is stable well before the device samples on the rising edge.
- Pulses and ready:
  - done and error are never high in the same cycle.
  - tx_ready returns high the cycle after the done or error pulse.

Decomposition:
- ps2_pkg holds:
  - state enum: IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE, OK, FAIL;
  - command constants: CMD_SET_LEDS=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF;
  - default timing constants.
- Sub-module ps2_line_sync holds the 3-flop synchroniser plus falling-edge detect. It is shared with the receive path.

Test Plan:
- Basic command, 0xED: tx_valid with 0xED.
  - Required: clock_oe=1 for exactly 6500 cycles, then data_oe=1 and clock_oe=0 in the same cycle.
  - Model device clocks out the bits, LSB first: 1,0,1,1,0,1,1,1, then parity 1, then stop 1. It drives the ACK low.
  - Required: done pulses once and error stays 0.
- Parity, 0xF4 (5 ones): parity bit 0, so data_oe=1 after fall 9; done pulses.
- No ACK: device leaves data high on fall 11 -> error pulses once, done=0, both oe=0, tx_ready=1 on the next cycle.
- Start timeout: device never clocks after REQ -> error pulses at START_TIMEOUT and both lines are released.
- Reset mid-transfer: assert reset_n=0 after fall 5 -> clock_oe=0, data_oe=0 and busy=0 asynchronously, with no done or error. A later 0xFF transfer completes with done.
- Busy rejection: pulse tx_valid with 0x00 during SEND of 0xED -> the byte is ignored; only the 0xED bit pattern appears on the line.
